memory_responder: RTL and testbench
===================================

// Module: memory_responder
// PURPOSE
//  Memory-side responder for the multicycle core's memory_read/memory_write interface.
//  Owns a word-organised unified instruction/data RAM and serves one request at a time.
//  Returns read data and a one-cycle memory_ack after a programmable latency.
//  Sits between the datapath's lorD address mux and the RAM.
// PARAMETERS
//  DEPTH         1024  number of 32-bit words (power of two, >=2)
//  READ_LATENCY  1     cycles from request acceptance to read ack (1..15)
//  WRITE_LATENCY 1     cycles from request acceptance to write ack (1..15)
// PORTS
//  clk           in   1   single clock, rising edge
//  reset         in   1   synchronous, active-high
//  memory_read   in   1   read request, level, held until memory_ack
//  memory_write  in   1   write request, level, held until memory_ack
//  address       in   32  byte address; word index = address[$clog2(DEPTH)+1:2]
//  write_data    in   32  store data, sampled at acceptance
//  byte_enable   in   4   lane mask for writes (bit i -> write_data[8i+7:8i])
//  read_data     out  32  read result, valid with memory_ack, held afterwards
//  memory_ack    out  1   one-cycle completion pulse
//  memory_busy   out  1   high while a request is in flight (WAIT or RESP)
//  memory_error  out  1   only with MEMORY_ERROR_EN; pulses with memory_ack
// BEHAVIOUR
//  Reset: state=IDLE, read_data=0, memory_ack=0, memory_busy=0, memory_error=0,
//   latency counter=0. RAM contents not cleared.
//  States: IDLE -> WAIT -> RESP -> IDLE.
//  IDLE: if memory_write or memory_read is high, latch address, write_data,
//   byte_enable and op, then go to WAIT; counter loads op latency-1.
//   memory_write and memory_read both high: write wins; read is dropped (no ack for it).
//  WAIT: counter decrements each cycle; when it is 0, go to RESP on next edge.
//   Write: RAM lanes with byte_enable=1 are updated on the WAIT->RESP edge.
//   Read: read_data loads RAM[word] on the WAIT->RESP edge.
//  RESP: memory_ack=1 for exactly one cycle, then IDLE.
//  Ack timing: ack is high in cycle N+LATENCY+1, where N is the acceptance cycle.
//   With LATENCY=1, the request is seen at edge N and ack is high during N+2.
//  Initiator deasserts its request in the ack cycle. A request still high in IDLE
//   after RESP is accepted as a new transaction (back-to-back allowed, 1 idle cycle).
//  Inputs changing during WAIT/RESP are ignored (latched copy used).
//  byte_enable=0 on write: no RAM change, ack still issued.
//  Read of a word written by the immediately preceding transaction returns new data.
//  address[1:0] ignored (word access only); no misalignment handling.
//  Reset mid-operation (WAIT or RESP): abort to IDLE, no ack, no RAM write, read_data=0.
//  memory_busy = (state != IDLE).
// CONFIGURATION
//  MEMORY_ERROR_EN defined: address >= 4*DEPTH is out of range. Out-of-range write
//   does not modify RAM; out-of-range read returns read_data=0. memory_error=1 in the
//   ack cycle, 0 otherwise. Latency is unchanged.
//  MEMORY_ERROR_EN undefined: upper address bits are ignored (wrap modulo DEPTH).
//   The memory_error port is absent.
// TESTING
//  T1: reset, read addr 0x10 after writing 0xDEADBEEF with be=4'hF -> ack 2 cycles after accept, read_data=0xDEADBEEF.
//  T2: word 0x20 = 0x11223344, write be=4'b0101 data 0xAABBCCDD -> read gives 0x11BB33DD.
//  T3: READ_LATENCY=4, read -> memory_busy high 5 cycles, ack exactly 5 cycles after accept, single pulse.
//  T4: read and write both high, addr 0x8, data 0x5 -> one ack, RAM[2]=0x5, no second ack.
//  T5: reset asserted during WAIT of write 0x12345678 to 0x40 -> no ack; later read 0x40 returns old value.
//  T6: DEPTH=1024, write 0x1000+0x4 -> without macro aliases word 1; with MEMORY_ERROR_EN memory_error=1 and word 1 is unchanged.

Source files
------------

// File: rtl/memory_responder.sv
// ---------------------------------------------------------------------------
// memory_responder
//   Memory-side responder for the multicycle core's memory_read/memory_write
//   handshake. It owns a word-organised unified instruction/data RAM and
//   serves one request at a time. Each request walks IDLE -> WAIT -> RESP ->
//   IDLE. A one-cycle memory_ack is raised after the programmed latency.
//
//   Optional feature macro: MEMORY_ERROR_EN
//     defined   : addresses >= 4*DEPTH are out of range. Such writes are
//                 dropped and such reads return zero. memory_error pulses
//                 together with memory_ack.
//     undefined : upper address bits are ignored (the address wraps modulo
//                 DEPTH) and the memory_error port does not exist.
// ---------------------------------------------------------------------------
module memory_responder #(
   parameter int DEPTH         = 1024,  // 32-bit words, power of two, >= 2
   parameter int READ_LATENCY  = 1,     // 1..15 cycles, acceptance to read ack
   parameter int WRITE_LATENCY = 1      // 1..15 cycles, acceptance to write ack
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        memory_read,
   input  logic        memory_write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [3:0]  byte_enable,
   output logic [31:0] read_data,
   output logic        memory_ack,
   output logic        memory_busy
`ifdef MEMORY_ERROR_EN
   ,
   output logic        memory_error
`endif
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = 4;

   // The counter is loaded with latency-1 so that WAIT lasts exactly
   // LATENCY cycles before the single RESP cycle.
   localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   count;
   logic [CNT_W-1:0]   count_nxt;
   logic               accept;     // request taken this cycle (IDLE only)
   logic               done;       // last WAIT cycle: the RAM access happens now

   // Copy of the request taken at acceptance. Port changes after that are ignored.
   logic               op_write_q;
   logic [ADDR_W-1:0]  word_q;
   logic [31:0]        wdata_q;
   logic [3:0]         be_q;
   logic               in_range;   // latched request may touch the RAM

   logic [31:0]        ram [DEPTH];

`ifdef MEMORY_ERROR_EN
   logic               range_err_q;
   logic               unused_addr_bits;

   // Word access only: the byte offset within a word carries no meaning.
   assign unused_addr_bits = ^address[1:0];
   assign in_range         = ~range_err_q;
`else
   logic               unused_addr_bits;

   // Upper bits wrap modulo DEPTH. The byte offset within a word is ignored.
   assign unused_addr_bits = ^{address[31:ADDR_W+2], address[1:0]};
   assign in_range         = 1'b1;
`endif

   // State register and latency counter. Synchronous reset aborts any transfer.
   // NOTE: sequential state uses non-blocking (<=) assignments, so every
   // flop samples the pre-edge values and no read/write ordering race occurs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= '0;
      end else begin
         state <= state_nxt;
         count <= count_nxt;
      end
   end

   // Next-state, counter and handshake outputs, all decoded from the current state.
   // NOTE: every output of this block gets a default value first, so no path
   // can leave a signal unassigned and infer a latch.
   always_comb begin
      state_nxt   = state;
      count_nxt   = count;
      accept      = 1'b0;
      done        = 1'b0;
      memory_ack  = 1'b0;
      memory_busy = 1'b1;
      case (state)
         IDLE: begin
            memory_busy = 1'b0;
            if (memory_write || memory_read) begin
               accept    = 1'b1;
               state_nxt = WAIT;
               // When both requests are high, the write wins and the read is dropped.
               count_nxt = memory_write ? WR_LOAD : RD_LOAD;
            end
         end
         WAIT: begin
            if (count == '0) begin
               done      = 1'b1;
               state_nxt = RESP;
            end else begin
               count_nxt = count - 1'b1;
            end
         end
         RESP: begin
            memory_ack = 1'b1;
            state_nxt  = IDLE;
         end
         default: begin
            memory_busy = 1'b0;
            state_nxt   = IDLE;
         end
      endcase
   end

   // Capture the request at acceptance. These flops have no reset because
   // they are only used while a transfer is in flight.
   always_ff @(posedge clk) begin
      if (accept) begin
         op_write_q <= memory_write;
         word_q     <= address[ADDR_W+1:2];
         wdata_q    <= write_data;
         be_q       <= byte_enable;
`ifdef MEMORY_ERROR_EN
         range_err_q <= (address[31:ADDR_W+2] != '0);
`endif
      end
   end

`ifdef MEMORY_ERROR_EN
   // The error flag follows the ack cycle. Because it is decoded from state,
   // it is zero directly after reset.
   assign memory_error = (state == RESP) && range_err_q;
`endif

   // Byte-lane RAM write on the WAIT->RESP edge. Reset in that cycle cancels it.
   // NOTE: the RAM array is deliberately not reset. Clearing it would need a
   // per-word reset network, and its contents are not defined after reset.
   always_ff @(posedge clk) begin
      if (!reset && done && op_write_q && in_range) begin
         for (int lane = 0; lane < 4; lane++) begin
            if (be_q[lane]) begin
               ram[word_q][8*lane +: 8] <= wdata_q[8*lane +: 8];
            end
         end
      end
   end

   // Read result register: it loads on the WAIT->RESP edge and holds afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         read_data <= '0;
      end else if (done && !op_write_q) begin
         read_data <= in_range ? ram[word_q] : '0;
      end
   end

endmodule

// File: tb/tb_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_memory_responder
//   Two responders: inst 0 uses the default latencies (1/1) and inst 1 uses
//   READ_LATENCY=4, WRITE_LATENCY=2. A transaction-level model predicts
//   busy/ack/read_data (and memory_error with MEMORY_ERROR_EN) from the
//   request inputs alone. The model knows only these timing rules:
//     - a request accepted at edge e has its RAM access at edge e+L;
//     - ack is high in the cycle after that edge;
//     - the next request can be accepted at edge e+L+2.
//   One process compares the model against both DUTs every cycle. Directed
//   tests add hand-computed literal checks.
// ---------------------------------------------------------------------------
module tb_memory_responder;

   localparam int DEPTH = 1024;
   localparam int NI    = 2;

   logic        clk = 1'b0;
   logic        reset;
   logic        rd    [NI];
   logic        wr    [NI];
   logic [31:0] addr  [NI];
   logic [31:0] wdata [NI];
   logic [3:0]  be    [NI];
   logic [31:0] rdata [NI];
   logic        ack   [NI];
   logic        busy  [NI];
`ifdef MEMORY_ERROR_EN
   logic        err   [NI];
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   memory_responder #(.DEPTH(DEPTH), .READ_LATENCY(1), .WRITE_LATENCY(1)) dut0 (
      .clk          (clk),
      .reset        (reset),
      .memory_read  (rd[0]),
      .memory_write (wr[0]),
      .address      (addr[0]),
      .write_data   (wdata[0]),
      .byte_enable  (be[0]),
      .read_data    (rdata[0]),
      .memory_ack   (ack[0]),
      .memory_busy  (busy[0])
`ifdef MEMORY_ERROR_EN
      ,
      .memory_error (err[0])
`endif
   );

   memory_responder #(.DEPTH(DEPTH), .READ_LATENCY(4), .WRITE_LATENCY(2)) dut1 (
      .clk          (clk),
      .reset        (reset),
      .memory_read  (rd[1]),
      .memory_write (wr[1]),
      .address      (addr[1]),
      .write_data   (wdata[1]),
      .byte_enable  (be[1]),
      .read_data    (rdata[1]),
      .memory_ack   (ack[1]),
      .memory_busy  (busy[1])
`ifdef MEMORY_ERROR_EN
      ,
      .memory_error (err[1])
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- transaction-level model ----------------
   function automatic int lat(input int i, input bit is_wr);
      if (i == 0) return 1;
      return is_wr ? 2 : 4;
   endfunction

   int          edge_k = 0;
   bit          started = 1'b0;
   bit          pend      [NI];
   int          done_e    [NI];
   int          next_free [NI];
   bit          p_wr      [NI];
   bit          p_oor     [NI];
   int          p_word    [NI];
   logic [31:0] p_data    [NI];
   logic [3:0]  p_be      [NI];
   logic [31:0] smem      [NI][DEPTH];
   bit          known     [NI][DEPTH];
   logic [31:0] exp_rd    [NI];
   bit          rd_known  [NI];
   bit          exp_busy  [NI];
   bit          exp_ack   [NI];
   bit          exp_err   [NI];

   initial begin
      for (int i = 0; i < NI; i++) begin
         pend[i] = 1'b0; next_free[i] = 0; done_e[i] = 0; rd_known[i] = 1'b0;
         for (int w = 0; w < DEPTH; w++) known[i][w] = 1'b0;
      end
      forever begin
         @(posedge clk);
         edge_k++;
         started = 1'b1;
         for (int i = 0; i < NI; i++) begin
            if (reset) begin
               pend[i]      = 1'b0;
               exp_rd[i]    = '0;
               rd_known[i]  = 1'b1;
               next_free[i] = edge_k + 1;
            end else begin
               if (pend[i] && edge_k == done_e[i]) begin
                  if (p_wr[i]) begin
                     if (!p_oor[i]) begin
                        for (int b = 0; b < 4; b++)
                           if (p_be[i][b]) smem[i][p_word[i]][8*b +: 8] = p_data[i][8*b +: 8];
                        if (p_be[i] == 4'hF) known[i][p_word[i]] = 1'b1;
                     end
                  end else begin
                     exp_rd[i]   = p_oor[i] ? 32'h0 : smem[i][p_word[i]];
                     rd_known[i] = p_oor[i] ? 1'b1 : known[i][p_word[i]];
                  end
               end else if (pend[i] && edge_k == done_e[i] + 1) begin
                  pend[i] = 1'b0;
               end
               if (!pend[i] && edge_k >= next_free[i] && (rd[i] || wr[i])) begin
                  pend[i]      = 1'b1;
                  p_wr[i]      = wr[i];
                  done_e[i]    = edge_k + lat(i, wr[i]);
                  next_free[i] = done_e[i] + 2;
                  p_word[i]    = int'((addr[i] >> 2) % DEPTH);
`ifdef MEMORY_ERROR_EN
                  p_oor[i]     = (addr[i] >= 32'(4 * DEPTH));
`else
                  p_oor[i]     = 1'b0;
`endif
                  p_data[i]    = wdata[i];
                  p_be[i]      = be[i];
               end
            end
            exp_busy[i] = pend[i];
            exp_ack[i]  = pend[i] && (edge_k == done_e[i]);
            exp_err[i]  = exp_ack[i] && p_oor[i];
         end
      end
   end

   // ---------------- per-cycle compare (mid-cycle) ----------------
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            for (int i = 0; i < NI; i++) begin
               check($sformatf("busy[%0d]", i), 32'(busy[i]), 32'(exp_busy[i]));
               check($sformatf("ack[%0d]", i), 32'(ack[i]), 32'(exp_ack[i]));
               if (rd_known[i]) check($sformatf("read_data[%0d]", i), rdata[i], exp_rd[i]);
`ifdef MEMORY_ERROR_EN
               check($sformatf("error[%0d]", i), 32'(err[i]), 32'(exp_err[i]));
`endif
            end
         end
      end
   end

   // ---------------- drivers ----------------
   // Raise a request and hold it until n_acks acks have been seen, then drop
   // it in the ack cycle. delay = cycles from acceptance to the first ack.
   task automatic xact(input int i, input bit r, input bit w, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b, input int n_acks,
                       output int delay, output int busy_n);
      int acks = 0;
      @(negedge clk);
      rd[i] = r; wr[i] = w; addr[i] = a; wdata[i] = d; be[i] = b;
      delay = 0; busy_n = 0;
      for (int c = 0; c < 40 && acks < n_acks; c++) begin
         @(negedge clk);
         if (busy[i]) busy_n++;
         if (ack[i]) begin
            acks++;
            if (acks == 1) delay = c + 1;
         end
      end
      check($sformatf("ack_count[%0d] addr %h", i, a), 32'(acks), 32'(n_acks));
      rd[i] = 1'b0; wr[i] = 1'b0;
   endtask

   task automatic idle(input int i, input int n, output int acks);
      acks = 0;
      repeat (n) begin
         @(negedge clk);
         if (ack[i]) acks++;
      end
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- directed stimulus ----------------
   initial begin
      int dl, bn, ak;
      reset = 1'b1;
      for (int i = 0; i < NI; i++) begin
         rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; be[i] = '0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < NI; i++) begin
         check("reset busy", 32'(busy[i]), 32'h0);
         check("reset ack", 32'(ack[i]), 32'h0);
         check("reset read_data", rdata[i], 32'h0);
      end

      // T1: write then read 0x10; ack two cycles after acceptance.
      xact(0, 0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, dl, bn);
      check("T1 write delay", 32'(dl), 32'd2);
      xact(0, 1, 0, 32'h10, 32'h0, 4'h0, 1, dl, bn);
      check("T1 read delay", 32'(dl), 32'd2);
      check("T1 read_data", rdata[0], 32'hDEADBEEF);
      xact(0, 1, 0, 32'h13, 32'h0, 4'h0, 1, dl, bn);
      check("offset ignored", rdata[0], 32'hDEADBEEF);

      // T2: partial byte write.
      xact(0, 0, 1, 32'h20, 32'h11223344, 4'hF, 1, dl, bn);
      xact(0, 0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 1, dl, bn);
      xact(0, 1, 0, 32'h20, 32'h0, 4'h0, 1, dl, bn);
      check("T2 read_data", rdata[0], 32'h11BB33DD);

      // T3: READ_LATENCY=4 instance.
      xact(1, 0, 1, 32'h30, 32'h0F0F0F0F, 4'hF, 1, dl, bn);
      check("T3 write delay", 32'(dl), 32'd3);
      xact(1, 1, 0, 32'h30, 32'h0, 4'h0, 1, dl, bn);
      check("T3 read delay", 32'(dl), 32'd5);
      check("T3 busy cycles", 32'(bn), 32'd5);
      check("T3 read_data", rdata[1], 32'h0F0F0F0F);
      idle(1, 4, ak);
      check("T3 single pulse", 32'(ak), 32'd0);

      // T4: read and write together; the write wins and only one ack is issued.
      xact(0, 1, 1, 32'h8, 32'h5, 4'hF, 1, dl, bn);
      idle(0, 3, ak);
      check("T4 no second ack", 32'(ak), 32'd0);
      xact(0, 1, 0, 32'h8, 32'h0, 4'h0, 1, dl, bn);
      check("T4 RAM[2]", rdata[0], 32'h5);

      // T5: reset during WAIT aborts the write.
      xact(0, 0, 1, 32'h40, 32'hA5A5A5A5, 4'hF, 1, dl, bn);
      @(negedge clk);
      wr[0] = 1'b1; addr[0] = 32'h40; wdata[0] = 32'h12345678; be[0] = 4'hF;
      @(negedge clk);
      check("T5 busy in WAIT", 32'(busy[0]), 32'h1);
      reset = 1'b1; wr[0] = 1'b0;
      @(negedge clk);
      reset = 1'b0;
      check("T5 no ack", 32'(ack[0]), 32'h0);
      check("T5 idle after reset", 32'(busy[0]), 32'h0);
      check("T5 read_data cleared", rdata[0], 32'h0);
      idle(0, 3, ak);
      check("T5 no late ack", 32'(ak), 32'd0);
      xact(0, 1, 0, 32'h40, 32'h0, 4'h0, 1, dl, bn);
      check("T5 old value", rdata[0], 32'hA5A5A5A5);

      // Back-to-back: a read held high through its ack is accepted again.
      xact(0, 0, 1, 32'h44, 32'h01020304, 4'hF, 1, dl, bn);
      xact(0, 1, 0, 32'h44, 32'h0, 4'h0, 2, dl, bn);
      check("b2b first delay", 32'(dl), 32'd2);
      check("b2b busy cycles", 32'(bn), 32'd4);
      check("b2b read_data", rdata[0], 32'h01020304);

      // byte_enable = 0: an ack is still issued, with no RAM change.
      xact(0, 0, 1, 32'h44, 32'hFFFFFFFF, 4'h0, 1, dl, bn);
      check("be0 delay", 32'(dl), 32'd2);
      xact(0, 1, 0, 32'h44, 32'h0, 4'h0, 1, dl, bn);
      check("be0 unchanged", rdata[0], 32'h01020304);

      // T6: address beyond the array.
      xact(0, 0, 1, 32'h4, 32'hCAFE0001, 4'hF, 1, dl, bn);
      xact(0, 0, 1, 32'h1004, 32'h0BADF00D, 4'hF, 1, dl, bn);
`ifdef MEMORY_ERROR_EN
      check("T6 error on write", 32'(err[0]), 32'h1);
`endif
      xact(0, 1, 0, 32'h4, 32'h0, 4'h0, 1, dl, bn);
`ifdef MEMORY_ERROR_EN
      check("T6 word1 unchanged", rdata[0], 32'hCAFE0001);
      xact(0, 1, 0, 32'h1004, 32'h0, 4'h0, 1, dl, bn);
      check("T6 oor read zero", rdata[0], 32'h0);
      check("T6 error on read", 32'(err[0]), 32'h1);
`else
      check("T6 alias word1", rdata[0], 32'h0BADF00D);
      xact(0, 1, 0, 32'h1004, 32'h0, 4'h0, 1, dl, bn);
      check("T6 alias read", rdata[0], 32'h0BADF00D);
`endif

      idle(0, 3, ak);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
